countdown_timer: RTL
====================

# countdown_timer

BCD minutes:seconds countdown timer driven by the one-cycle tick pulse of the rate divider, placed directly downstream of it (divider configured for 1 Hz). It holds a loadable MM:SS value, decrements once per tick while running, and reports BCD digits for the HEX displays. It also signals expiry to the game control FSM.

## Interface
- MIN_TENS_MAX, default 9: largest legal minutes-tens digit; loads above it clamp to it.
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle pulse from the rate divider; one pulse = one second
- load  in  1  latch load_min/load_sec
- load_min  in  8  BCD minutes {tens, ones}
- load_sec  in  8  BCD seconds {tens, ones}
- start  in  1  begin or resume counting
- stop  in  1  pause counting
- min_bcd  out  8  current minutes, BCD
- sec_bcd  out  8  current seconds, BCD
- running  out  1  high in RUN
- expired  out  1  high in DONE
- expire_pulse  out  1  one-cycle pulse on entry to DONE

## Operation
- States:
  - IDLE (2'd0)
  - RUN (2'd1)
  - PAUSE (2'd2)
  - DONE (2'd3)
- Reset values: state IDLE, count 00:00, all outputs 0.
- Load sanitising:
  - Any ones digit above 9 clamps to 9.
  - Seconds tens above 5 clamps to 5.
  - Minutes tens above MIN_TENS_MAX clamps to MIN_TENS_MAX.
- Priority per cycle: load > stop > start > tick.
- load (any state): write the clamped value and go to IDLE. Start, stop and tick are ignored that cycle.
- IDLE:
  - start with count ≠ 00:00 → RUN.
  - start with count = 00:00 is ignored.
  - stop is ignored.
- RUN:
  - stop → PAUSE with no decrement, even if tick is high.
  - tick → decrement.
  - A decrement that reaches 00:00 moves to DONE on the same edge.
- PAUSE:
  - start → RUN.
  - tick is ignored.
- DONE:
  - Count holds at 00:00.
  - start, stop and tick are ignored.
  - Only load or reset leaves DONE.
- Decrement arithmetic (BCD borrow chain):
  - sec ones 0 → 9 with borrow.
  - sec tens 0 → 5 with borrow.
  - min ones 0 → 9 with borrow.
  - min tens decrements.
  - Example: 10:00 → 09:59.

## Timing
- All outputs are registered. A change caused by an input sampled at edge N is visible after edge N.
- start in IDLE together with tick in the same cycle: enter RUN with no decrement. The first decrement is on the next tick.
- expire_pulse is high for exactly the one cycle after the edge that enters DONE. In that same cycle min_bcd/sec_bcd read 00:00 and expired rises.
- Back-to-back ticks on consecutive cycles are legal, and each one decrements.
- Reset mid-count: the asynchronous clear takes effect immediately, with no pulse emitted.

## Structure
- Shared include file, pulled into this block and the game control FSM:
  - state localparams IDLE/RUN/PAUSE/DONE
  - BCD limit constants SEC_TENS_MAX = 5 and DIGIT_MAX = 9
- One sub-module, bcd_digit_down:
  - Ports: clock, resetn, load, load_val[3:0], dec, max_val[3:0]; outputs digit[3:0] and borrow.
  - borrow is combinational: dec & (digit == 0).
  - Instantiated four times as a borrow chain.
- FSM and priority logic stay in countdown_timer.

## Test plan
- Reset then load 01:30 + start, 90 ticks: reaches 00:00 after the 90th tick. expire_pulse is high for one cycle, expired stays 1, running = 0.
- Load 10:00, start, 1 tick: reads 09:59. Load 00:01, start, 1 tick: DONE.
- Running at 00:45, stop and tick in the same cycle: holds 00:45 in PAUSE. 5 further ticks: still 00:45. start + 1 tick: 00:44.
- Load with load_sec = 8'h7C, load_min = 8'hAF: reads min 9F→clamped 99, sec 59, i.e. 99:59.
- Load 00:00 then start: stays IDLE, no expire_pulse. In DONE, start and tick: no change. load 00:05 → IDLE, reads 00:05.
- Running at 00:10, assert resetn low mid-cycle: outputs go to 00:00 with running = 0 before the next edge, and no expire_pulse.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared constants for the countdown timer and the game control FSM:
// state encodings, BCD digit limits and the load clamping helper.
package countdown_timer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] mx);
        logic [3:0] r;
        if (d > mx) begin
            r = mx;
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_digit_down.sv
// One BCD digit of a down-counting borrow chain: wraps to max_val on a
// decrement from zero and flags the borrow to the next, more significant digit.
module bcd_digit_down (
    input  logic       clock,
    input  logic       resetn,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    input  logic [3:0] max_val,
    output logic [3:0] digit,
    output logic       borrow
);

    logic [3:0] r_digit;

    // Digit register: load wins over decrement
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_digit <= 4'd0;
        end else if (load) begin
            r_digit <= load_val;
        end else if (dec) begin
            if (r_digit == 4'd0) begin
                r_digit <= max_val;
            end else begin
                r_digit <= r_digit - 4'd1;
            end
        end else begin
            r_digit <= r_digit;
        end
    end

    assign digit  = r_digit;
    assign borrow = dec & (r_digit == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with load/start/stop control, fed by a 1 Hz tick
// pulse; reports digits for display and signals expiry to game control.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter logic [3:0] MIN_TENS_MAX = 4'd9
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       expired,
    output logic       expire_pulse
);

    logic [1:0] r_state;
    logic       r_running;
    logic       r_expired;
    logic       r_expire_pulse;

    logic [1:0] w_state_nx;
    logic       w_dec;
    logic       w_count_zero;
    logic       w_count_one;
    logic [3:0] w_sec_ones;
    logic [3:0] w_sec_tens;
    logic [3:0] w_min_ones;
    logic [3:0] w_min_tens;
    logic       w_borrow_so;
    logic       w_borrow_st;
    logic       w_borrow_mo;
    logic       w_unused_borrow_mt;

    assign w_count_zero = ({w_min_tens, w_min_ones, w_sec_tens, w_sec_ones} == 16'h0000);
    assign w_count_one  = ({w_min_tens, w_min_ones, w_sec_tens, w_sec_ones} == 16'h0001);

    // Next state and decrement enable; load > stop > start > tick
    always_comb begin
        w_state_nx = r_state;
        w_dec      = 1'b0;
        if (load) begin
            w_state_nx = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !w_count_zero) begin
                        w_state_nx = ST_RUN;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        w_state_nx = ST_PAUSE;
                    end else if (tick) begin
                        w_dec = 1'b1;
                        if (w_count_one) begin
                            w_state_nx = ST_DONE;
                        end else begin
                            w_state_nx = ST_RUN;
                        end
                    end else begin
                        w_state_nx = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (stop) begin
                        w_state_nx = ST_PAUSE;
                    end else if (start) begin
                        w_state_nx = ST_RUN;
                    end else begin
                        w_state_nx = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    w_state_nx = ST_DONE;
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // State and status outputs, registered from the next state
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state        <= ST_IDLE;
            r_running      <= 1'b0;
            r_expired      <= 1'b0;
            r_expire_pulse <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_running      <= (w_state_nx == ST_RUN);
            r_expired      <= (w_state_nx == ST_DONE);
            r_expire_pulse <= (w_state_nx == ST_DONE) && (r_state != ST_DONE);
        end
    end

    bcd_digit_down u_sec_ones (
        .clock    (clock),
        .resetn   (resetn),
        .load     (load),
        .load_val (clamp_digit(load_sec[3:0], DIGIT_MAX)),
        .dec      (w_dec),
        .max_val  (DIGIT_MAX),
        .digit    (w_sec_ones),
        .borrow   (w_borrow_so)
    );

    bcd_digit_down u_sec_tens (
        .clock    (clock),
        .resetn   (resetn),
        .load     (load),
        .load_val (clamp_digit(load_sec[7:4], SEC_TENS_MAX)),
        .dec      (w_borrow_so),
        .max_val  (SEC_TENS_MAX),
        .digit    (w_sec_tens),
        .borrow   (w_borrow_st)
    );

    bcd_digit_down u_min_ones (
        .clock    (clock),
        .resetn   (resetn),
        .load     (load),
        .load_val (clamp_digit(load_min[3:0], DIGIT_MAX)),
        .dec      (w_borrow_st),
        .max_val  (DIGIT_MAX),
        .digit    (w_min_ones),
        .borrow   (w_borrow_mo)
    );

    // The top borrow can only fire from 00:00, which never decrements
    bcd_digit_down u_min_tens (
        .clock    (clock),
        .resetn   (resetn),
        .load     (load),
        .load_val (clamp_digit(load_min[7:4], MIN_TENS_MAX)),
        .dec      (w_borrow_mo),
        .max_val  (MIN_TENS_MAX),
        .digit    (w_min_tens),
        .borrow   (w_unused_borrow_mt)
    );

    assign min_bcd      = {w_min_tens, w_min_ones};
    assign sec_bcd      = {w_sec_tens, w_sec_ones};
    assign running      = r_running;
    assign expired      = r_expired;
    assign expire_pulse = r_expire_pulse;

endmodule
